// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60 default timing values and shared coordinate type
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrap counter with registered sync/last decode
// Active/zero decodes are exported from the next count so the top can register them in step.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_step,
    output logic [9:0] o_count,
    output logic       o_sync_n,
    output logic       o_at_last,
    output logic       o_active_nxt,
    output logic       o_at_zero_nxt
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    generate
        if (TOTAL > 1024) begin : g_bad_total
            $error("vga_axis_counter: TOTAL %0d does not fit a 10-bit counter", TOTAL);
        end
    endgenerate

    localparam coord_t C_LAST      = coord_t'(TOTAL - 1);
    localparam coord_t C_ACTIVE    = coord_t'(ACTIVE);
    localparam coord_t C_SYNC_BEG  = coord_t'(ACTIVE + FP);
    localparam coord_t C_SYNC_END  = coord_t'(ACTIVE + FP + SYNC);

    coord_t r_count;
    coord_t w_next;
    logic   r_sync_n;
    logic   r_at_last;

    always_comb begin
        w_next = r_count;
        if (i_step) begin
            w_next = (r_count == C_LAST) ? '0 : r_count + 10'd1;
        end
    end

    // i_en without i_step reloads the decodes for the current count (first cycle after reset)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_sync_n  <= 1'b1;
            r_at_last <= 1'b0;
        end else if (i_en) begin
            r_count   <= w_next;
            r_sync_n  <= !((w_next >= C_SYNC_BEG) && (w_next < C_SYNC_END));
            r_at_last <= (w_next == C_LAST);
        end
    end

    assign o_count       = r_count;
    assign o_sync_n      = r_sync_n;
    assign o_at_last     = r_at_last;
    assign o_active_nxt  = (w_next < C_ACTIVE);
    assign o_at_zero_nxt = (w_next == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_PIX_DIV_EN enables a divide-by-2 pixel tick
// All outputs are flops decoding the Q_X/Q_Y presented in the same cycle.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] Q_X,
    output logic [9:0] Q_Y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start,
    output logic       pix_tick
);

    logic   w_tick_next;
    logic   w_run;
    logic   w_h_step;
    logic   w_v_step;
    logic   w_h_last;
    logic   w_v_at_last_unused;
    logic   w_h_act;
    logic   w_v_act;
    logic   w_h_zero;
    logic   w_v_zero;
    logic   r_pix_tick;
    logic   r_video_on;
    logic   r_line_start;
    logic   r_frame_start;

`ifdef VGA_PIX_DIV_EN
    logic r_toggle;
    logic r_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_toggle <= 1'b0;
            r_run    <= 1'b0;
        end else begin
            r_toggle <= ~r_toggle;
            r_run    <= 1'b1;
        end
    end

    assign w_tick_next = ~r_toggle;
    assign w_run       = r_run;
`else
    assign w_tick_next = 1'b1;
    assign w_run       = r_pix_tick;
`endif

    // The first tick after reset only loads decodes for (0,0); later ticks advance
    assign w_h_step = w_tick_next & w_run;
    assign w_v_step = w_h_step & w_h_last;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h (
        .clk           (clk),
        .rst           (rst),
        .i_en          (w_tick_next),
        .i_step        (w_h_step),
        .o_count       (Q_X),
        .o_sync_n      (hsync),
        .o_at_last     (w_h_last),
        .o_active_nxt  (w_h_act),
        .o_at_zero_nxt (w_h_zero)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v (
        .clk           (clk),
        .rst           (rst),
        .i_en          (w_tick_next),
        .i_step        (w_v_step),
        .o_count       (Q_Y),
        .o_sync_n      (vsync),
        .o_at_last     (w_v_at_last_unused),
        .o_active_nxt  (w_v_act),
        .o_at_zero_nxt (w_v_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_tick    <= 1'b0;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_tick <= w_tick_next;
            if (w_tick_next) begin
                r_video_on    <= w_h_act & w_v_act;
                r_line_start  <= w_h_zero;
                r_frame_start <= w_h_zero & w_v_zero;
            end
        end
    end

    assign pix_tick    = r_pix_tick;
    assign video_on    = r_video_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (short vertical timing keeps frames brief)
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int HA = H_ACTIVE;
    localparam int HF = H_FP;
    localparam int HS = H_SYNC;
    localparam int HT = H_TOTAL;
    localparam int VA = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VT = VA + VF + VS + VB;
`ifdef VGA_PIX_DIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ls;
        logic       fs;
        logic       pix;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] Q_X;
    logic [9:0] Q_Y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       line_start;
    logic       frame_start;
    logic       pix_tick;

    always #20 clk = ~clk;

    vga_timing_gen #(
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Q_X         (Q_X),
        .Q_Y         (Q_Y),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .line_start  (line_start),
        .frame_start (frame_start),
        .pix_tick    (pix_tick)
    );

    obs_t  q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    mx = 0;
    int    my = 0;
    logic  m_pix = 1'b0;
    logic  m_run = 1'b0;
    string phase = "reset";
    int    cyc_cnt = 0;
    int    hs_low = 0, hs_first = -1, hs_last = -1;
    int    vs_low = 0, vs_first = -1, vs_last = -1;
    int    last_fs = -1, period = 0;
    logic  fs_q = 1'b0;

    function automatic obs_t model(input logic r);
        obs_t e;
        if (r) begin
            e.x = '0; e.y = '0; e.hs = 1'b1; e.vs = 1'b1;
            e.von = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.pix = 1'b0;
        end else begin
            e.x   = 10'(mx);
            e.y   = 10'(my);
            e.hs  = !((mx >= HA + HF) && (mx < HA + HF + HS));
            e.vs  = !((my >= VA + VF) && (my < VA + VF + VS));
            e.von = (mx < HA) && (my < VA);
            e.ls  = (mx == 0);
            e.fs  = (mx == 0) && (my == 0);
            e.pix = m_pix;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r);
        obs_t e;
        obs_t o;
        logic nxt;
        rst = r;
        if (r) begin
            mx = 0; my = 0; m_pix = 1'b0; m_run = 1'b0;
        end else begin
            nxt = (DIV == 2) ? !m_pix : 1'b1;
            if (nxt) begin
                if (m_run) begin
                    mx++;
                    if (mx == HT) begin
                        mx = 0;
                        my++;
                        if (my == VT) my = 0;
                    end
                end
                m_run = 1'b1;
            end
            m_pix = nxt;
        end
        q.push_back(model(r));
        @(posedge clk);
        #1;
        cyc_cnt++;
        o = {Q_X, Q_Y, hsync, vsync, video_on, line_start, frame_start, pix_tick};
        e = q.pop_front();
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed x=%0d y=%0d hs%b vs%b von%b ls%b fs%b pix%b expected x=%0d y=%0d hs%b vs%b von%b ls%b fs%b pix%b",
                   phase, o.x, o.y, o.hs, o.vs, o.von, o.ls, o.fs, o.pix,
                   e.x, e.y, e.hs, e.vs, e.von, e.ls, e.fs, e.pix);
        end
        n_tests++;
        assert (!(frame_start && !line_start)) else begin
            n_fail++;
            $error("FAIL fs_without_ls: observed fs=%b ls=%b expected ls=1", frame_start, line_start);
        end
        if (!hsync) begin
            hs_low++;
            hs_last = int'(Q_X);
            if (hs_first < 0) hs_first = int'(Q_X);
        end
        if (!vsync) begin
            vs_low++;
            vs_last = int'(Q_Y);
            if (vs_first < 0) vs_first = int'(Q_Y);
        end
        if (frame_start && !fs_q) begin
            if (last_fs >= 0) period = cyc_cnt - last_fs;
            last_fs = cyc_cnt;
        end
        fs_q = frame_start;
    endtask

    task automatic pix();
        repeat (DIV) cyc(1'b0);
    endtask

    initial begin
        phase = "reset";
        repeat (5) cyc(1'b1);
        check("reset_q", {Q_X, Q_Y}, 0);
        check("reset_sync", {hsync, vsync}, 2'b11);
        check("reset_pulses", {video_on, line_start, frame_start, pix_tick}, 0);

        phase = "first";
        cyc(1'b0);
        check("first_q", {Q_X, Q_Y}, 0);
        check("first_fs", frame_start, 1);
        check("first_von", video_on, 1);
        check("first_pix", pix_tick, 1);

        phase = "line0";
        repeat (639) pix();
        check("x639", Q_X, 639);
        check("von639", video_on, 1);
        pix();
        check("x640", Q_X, 640);
        check("von640", video_on, 0);
        hs_low = 0; hs_first = -1; hs_last = -1;
        repeat (159) pix();
        check("x799", Q_X, 799);
        check("hs_low_cycles", hs_low, HS * DIV);
        check("hs_first_x", hs_first, HA + HF);
        check("hs_last_x", hs_last, HA + HF + HS - 1);
        pix();
        check("wrap_x", Q_X, 0);
        check("wrap_y", Q_Y, 1);
        check("wrap_ls", line_start, 1);

        phase = "frame";
        vs_low = 0; vs_first = -1; vs_last = -1;
        repeat ((VT - 1) * HT - 1) pix();
        check("last_q", {Q_X, Q_Y}, {10'd799, 10'(VT - 1)});
        check("vs_low_cycles", vs_low, VS * HT * DIV);
        check("vs_first_y", vs_first, VA + VF);
        check("vs_last_y", vs_last, VA + VF + VS - 1);
        pix();
        check("frame_wrap_q", {Q_X, Q_Y}, 0);
        check("frame_wrap_fs", frame_start, 1);
        check("frame_period", period, HT * VT * DIV);

        phase = "midreset";
        repeat (4 * HT + 300) pix();
        check("pre_rst_q", {Q_X, Q_Y}, {10'd300, 10'd4});
        cyc(1'b1);
        check("rst_q", {Q_X, Q_Y}, 0);
        check("rst_sync", {hsync, vsync}, 2'b11);
        check("rst_pulses", {video_on, line_start, frame_start}, 0);
        cyc(1'b0);
        check("restart_fs", frame_start, 1);
        pix();
        check("restart_x1", {Q_X, Q_Y}, {10'd1, 10'd0});

        phase = "frames";
        repeat (2 * HT * VT - 1) pix();
        check("two_frames_q", {Q_X, Q_Y}, 0);
        check("two_frames_fs", frame_start, 1);
        check("two_frames_period", period, HT * VT * DIV);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
